// File: rtl/fifo_push_arbiter_pkg.sv
// Shared types for the FIFO push arbiter: FSM encoding and round-robin helper width.
package fifo_push_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // Largest supported requester count; sizes the wrap-around sum in rr_select.
  localparam int RR_MAX_REQ = 8;
  localparam int RR_IDX_W   = $clog2(RR_MAX_REQ);

endpackage

// File: rtl/fifo_push_arbiter_rr_select.sv
// Round-robin priority selector: first requesting index strictly after last_grant, wrapping.
// Purely combinational; found=0 when no request bit is set.
module rr_select
  import fifo_push_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [RR_IDX_W:0] sum;
  logic [IDX_W-1:0]  cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    // Offset NUM_REQ lands back on last_grant itself, so it has lowest priority.
    for (int k = 1; k <= NUM_REQ; k++) begin
      sum  = (RR_IDX_W+1)'(last_grant) + (RR_IDX_W+1)'(k);
      cand = IDX_W'(sum % (RR_IDX_W+1)'(NUM_REQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter pushing one requester's beats into a FIFO; one idle bubble per grant,
// push is combinational in BURST. fifo_full stalls the owner (req_ready low) without losing state.
module fifo_push_arbiter
  import fifo_push_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_push,
  output logic [DATA_WIDTH-1:0]         fifo_din,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] beat_cnt_inc;
  logic [IDX_W-1:0] rr_idx;
  logic             rr_found;
  logic             xfer;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .idx        (rr_idx),
    .found      (rr_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      beat_cnt_q   <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      beat_cnt_q   <= beat_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign beat_cnt_inc = beat_cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    beat_cnt_d   = beat_cnt_q;
    last_grant_d = last_grant_q;
    req_ready    = '0;
    fifo_push    = 1'b0;
    fifo_din     = '0;
    grant_valid  = 1'b0;
    grant_id     = '0;
    xfer         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          owner_d    = rr_idx;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        // Outputs are masked during reset so an abandoned burst never pushes.
        if (!reset) begin
          grant_valid        = 1'b1;
          grant_id           = owner_q;
          req_ready[owner_q] = !fifo_full;
          fifo_din           = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
          xfer               = req_valid[owner_q] && !fifo_full;
          fifo_push          = xfer;
        end
        if (xfer) begin
          beat_cnt_d = beat_cnt_inc;
          if (req_last[owner_q] || beat_cnt_inc == CNT_W'(MAX_BURST)) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: vector table, corner-case sequences, randomized run vs. reference model.
module tb_fifo_push_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_push;
  logic [7:0]  fifo_din;
  logic        grant_valid;
  logic [1:0]  grant_id;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_push_arbiter #(
    .DATA_WIDTH (8),
    .NUM_REQ    (4),
    .MAX_BURST  (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_push   (fifo_push),
    .fifo_din    (fifo_din),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [3:0] lst;
    logic       full;
    logic [3:0] rdy;
    logic       push;
    logic [7:0] din;
    logic       gv;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read 3 units later.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic f, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset     = r;
    req_valid = v;
    req_last  = l;
    fifo_full = f;
    req_data  = d;
    #3;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 32'h0);
  endtask

  initial begin
    logic [9:0]  pv, gvv, rv;
    logic [31:0] d;
    int          sent;
    int          m_owner, m_beats, m_last;
    logic        r, f;
    logic [3:0]  v, l;
    logic [3:0]  e_rdy;
    logic        e_push, e_gv;
    logic [7:0]  e_din;
    logic [1:0]  e_gid;

    reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;

    // Single packet from 0, then round-robin 0,1,2,3,0, then a stall.
    tbl[0]  = '{1'b1, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[6]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};
    tbl[7]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1};
    tbl[9]  = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[10] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'hC2, 1'b1, 2'd2};
    tbl[11] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[12] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b1000, 1'b1, 8'hD3, 1'b1, 2'd3};
    tbl[13] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[14] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};
    tbl[15] = '{1'b0, 4'b0000, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[16] = '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
    tbl[17] = '{1'b0, 4'b0001, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'hA5, 1'b1, 2'd0};
    tbl[18] = '{1'b0, 4'b0001, 4'b1111, 1'b0, 4'b0001, 1'b1, 8'hA5, 1'b1, 2'd0};

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].lst, tbl[i].full, 32'hD3C2B1A5);
      chk($sformatf("vec%0d_ready", i), 32'(req_ready),   32'(tbl[i].rdy));
      chk($sformatf("vec%0d_push", i),  32'(fifo_push),   32'(tbl[i].push));
      chk($sformatf("vec%0d_din", i),   32'(fifo_din),    32'(tbl[i].din));
      chk($sformatf("vec%0d_gv", i),    32'(grant_valid), 32'(tbl[i].gv));
      chk($sformatf("vec%0d_gid", i),   32'(grant_id),    32'(tbl[i].gid));
    end

    // Requester 2 streams 6 beats without last: 4-beat burst, bubble, regrant, then holds.
    do_reset();
    sent = 0; pv = '0; gvv = '0;
    for (int c = 0; c < 10; c++) begin
      d = '0;
      d[23:16] = 8'h20 + 8'(sent);
      drive(1'b0, (sent < 6) ? 4'b0100 : 4'b0000, 4'b0000, 1'b0, d);
      pv[c]  = fifo_push;
      gvv[c] = grant_valid;
      if (fifo_push) begin
        chk("maxburst_din", 32'(fifo_din), 32'(8'h20 + 8'(sent)));
        chk("maxburst_gid", 32'(grant_id), 32'd2);
        sent++;
      end
    end
    chk("maxburst_push_pattern", 32'(pv),  32'(10'b0011011110));
    chk("maxburst_gv_pattern",   32'(gvv), 32'(10'b1111011110));

    // Three full cycles after the first beat of requester 1.
    do_reset();
    sent = 0; pv = '0; rv = '0;
    for (int c = 0; c < 10; c++) begin
      d = '0;
      d[15:8] = 8'h40 + 8'(sent);
      drive(1'b0, (sent < 4) ? 4'b0010 : 4'b0000, 4'b0000, (c >= 2 && c <= 4), d);
      pv[c] = fifo_push;
      rv[c] = req_ready[1];
      if (fifo_push) begin
        chk("stall_din", 32'(fifo_din), 32'(8'h40 + 8'(sent)));
        sent++;
      end
      if (c == 8) chk("stall_idle_after", 32'(grant_valid), 32'd0);
    end
    chk("stall_push_pattern",  32'(pv), 32'(10'b0011100010));
    chk("stall_ready_pattern", 32'(rv), 32'(10'b0011100010));
    chk("stall_beats",         32'(sent), 32'd4);

    // Reset on the second cycle of a burst by requester 1.
    do_reset();
    drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0000_1100);
    drive(1'b0, 4'b0010, 4'b0000, 1'b0, 32'h0000_1100);
    chk("rst_mid_first_push", 32'(fifo_push), 32'd1);
    drive(1'b1, 4'b1010, 4'b0000, 1'b0, 32'h0000_1100);
    chk("rst_mid_push", 32'(fifo_push),   32'd0);
    chk("rst_mid_gv",   32'(grant_valid), 32'd0);
    drive(1'b0, 4'b1010, 4'b0000, 1'b0, 32'h0000_1100);
    chk("rst_after_push", 32'(fifo_push),   32'd0);
    chk("rst_after_gv",   32'(grant_valid), 32'd0);
    drive(1'b0, 4'b1010, 4'b0000, 1'b0, 32'h0000_1100);
    chk("rst_regrant_gid", 32'(grant_id),  32'd1);
    chk("rst_regrant_gv",  32'(grant_valid), 32'd1);

    // Owner 0 drops valid for two cycles while requester 3 waits.
    do_reset();
    drive(1'b0, 4'b1001, 4'b0000, 1'b0, 32'h3300_0011);
    drive(1'b0, 4'b1001, 4'b0000, 1'b0, 32'h3300_0011);
    chk("hold_first_push", 32'(fifo_push), 32'd1);
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h3300_0011);
      chk("hold_gid",   32'(grant_id),  32'd0);
      chk("hold_push",  32'(fifo_push), 32'd0);
      chk("hold_ready", 32'(req_ready), 32'b0001);
    end
    drive(1'b0, 4'b1001, 4'b0001, 1'b0, 32'h3300_0022);
    chk("hold_last_din", 32'(fifo_din), 32'h22);
    drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h3300_0022);
    chk("hold_bubble_gv", 32'(grant_valid), 32'd0);
    drive(1'b0, 4'b1000, 4'b0000, 1'b0, 32'h3300_0022);
    chk("hold_next_gid",  32'(grant_id),  32'd3);
    chk("hold_next_push", 32'(fifo_push), 32'd1);

    // Randomized traffic against a transaction-level model (owner -1 means no grant).
    m_owner = -1; m_beats = 0; m_last = 3;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = (cyc == 0) || ($urandom_range(0, 59) == 0);
      v = 4'($urandom);
      for (int i = 0; i < 4; i++) l[i] = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 3) == 0);
      d = $urandom;
      drive(r, v, l, f, d);

      e_rdy = '0; e_push = 1'b0; e_din = '0; e_gv = 1'b0; e_gid = '0;
      if (!r && m_owner >= 0) begin
        e_gv   = 1'b1;
        e_gid  = 2'(m_owner);
        e_rdy  = f ? 4'b0000 : 4'(1 << m_owner);
        e_push = v[m_owner] && !f;
        e_din  = 8'(d >> (8 * m_owner));
      end
      chk("rand_ready", 32'(req_ready),   32'(e_rdy));
      chk("rand_push",  32'(fifo_push),   32'(e_push));
      chk("rand_din",   32'(fifo_din),    32'(e_din));
      chk("rand_gv",    32'(grant_valid), 32'(e_gv));
      chk("rand_gid",   32'(grant_id),    32'(e_gid));

      if (r) begin
        m_owner = -1; m_beats = 0; m_last = 3;
      end else if (m_owner < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (m_owner < 0 && v[(m_last + k) % 4]) begin
            m_owner = (m_last + k) % 4;
            m_beats = 0;
          end
        end
      end else if (e_push) begin
        m_beats++;
        if (l[m_owner] || m_beats == 4) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_push_arbiter.md
FIFO_PUSH_ARBITER -- requirements
Module: fifo_push_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of requester data and FIFO write data.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (power of two, 2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..16).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, reset; it is synchronous and active-high.
REQ-006 SHALL have port req_valid, input, NUM_REQ, per-requester data-valid.
REQ-007 SHALL have port req_last, input, NUM_REQ, per-requester end-of-packet flag, qualified by req_valid.
REQ-008 SHALL have port req_data, input, NUM_REQ*DATA_WIDTH, packed data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port req_ready, output, NUM_REQ, per-requester accept; a beat transfers when valid and ready are both high.
REQ-010 SHALL have port fifo_full, input, 1, full flag from the downstream FIFO.
REQ-011 SHALL have port fifo_push, output, 1, push strobe to the FIFO.
REQ-012 SHALL have port fifo_din, output, DATA_WIDTH, write data to the FIFO.
REQ-013 SHALL have port grant_valid, output, 1, high while a requester owns the FIFO.
REQ-014 SHALL have port grant_id, output, clog2(NUM_REQ), index of the current owner.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BURST.
REQ-016 In IDLE with any req_valid high, SHALL select the first requesting index after last_grant (round-robin, wrapping NUM_REQ-1 to 0), register it as owner, clear beat_cnt, and enter BURST on the next edge; one arbitration bubble cycle, no push in IDLE.
REQ-017 In IDLE with no req_valid, SHALL remain in IDLE with grant_valid=0.
REQ-018 In BURST, req_ready[owner] = !fifo_full, all other req_ready = 0, and fifo_push = req_valid[owner] && !fifo_full (combinational).
REQ-019 fifo_din SHALL equal req_data slice of owner in BURST, else 0.
REQ-020 Each transfer SHALL increment beat_cnt (width clog2(MAX_BURST)+1, no wrap).
REQ-021 BURST SHALL exit to IDLE after a transfer with req_last[owner]=1 or with beat_cnt+1 == MAX_BURST, and SHALL set last_grant=owner at that edge.
REQ-022 In BURST, owner deasserting req_valid or fifo_full high SHALL hold state, owner and beat_cnt (no timeout, no pre-emption).
REQ-023 fifo_push SHALL never assert while fifo_full=1; at most one push per cycle.
REQ-024 grant_valid = (state==BURST); grant_id = owner in BURST, 0 in IDLE.
REQ-025 Changes to non-owner req_valid during BURST SHALL have no effect until the next IDLE.

Reset
REQ-026 When reset=1 at a clock edge: state=IDLE, owner=0, beat_cnt=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
REQ-027 Outputs during and after reset until first grant: req_ready=0, fifo_push=0, fifo_din=0, grant_valid=0, grant_id=0.
REQ-028 Reset mid-BURST SHALL abandon the burst without a push in the reset cycle; partial packets are the requester's concern.

Structure
REQ-029 FSM state encoding and the round-robin helper width constant SHALL live in a shared package.
REQ-030 The round-robin priority selector (request vector + last_grant -> next index, found flag) SHALL be one combinational sub-module, rr_select.
REQ-031 Total RTL SHALL be 120-400 lines; no FIFO storage inside this block.

Verification
REQ-032 Reset then req_valid=4'b0001, data 0xA5, last=1 -> grant_id=0 one cycle later, fifo_push one cycle with din=0xA5, return to IDLE.
REQ-033 All four requesters valid, last=1 each beat -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-034 Requester 2 streams 6 beats with last=0, MAX_BURST=4 -> exactly 4 pushes, then IDLE, then a new grant to 2 (only requester) for remaining beats.
REQ-035 fifo_full=1 for 3 cycles mid-burst -> fifo_push=0 and req_ready[owner]=0 for those cycles, no beat lost or duplicated, beat_cnt unchanged.
REQ-036 reset asserted on cycle 2 of a burst by requester 1 -> next cycle grant_valid=0, fifo_push=0; first subsequent grant goes to lowest requesting index from 0.
REQ-037 Owner drops req_valid for 2 cycles with requester 3 valid -> ownership retained, no push to 3 until owner's burst ends.
